// File: rtl/traffic_light_ctrl_if.sv
// Traffic controller signal bundle: timer handshake, sensor/button inputs, lamp outputs.
// The master modport drives the inputs (environment/bench); the slave modport is the controller.
// Pure wiring; carries no state of its own.
interface traffic_light_ctrl_if;
  logic       sensor;
  logic       walk_request;
  logic       expired;
  logic [4:0] value;
  logic       start_timer;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk;

  modport master (
    output sensor,
    output walk_request,
    output expired,
    input  value,
    input  start_timer,
    input  main_light,
    input  side_light,
    input  walk
  );

  modport slave (
    input  sensor,
    input  walk_request,
    input  expired,
    output value,
    output start_timer,
    output main_light,
    output side_light,
    output walk
  );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Intersection sequencer driving main/side lamps, a pedestrian walk lamp and an external Timer.
// Latency: a qualified expiry in cycle M shows the next state's lamps and load pulse in cycle M+1.
// Backpressure: none; expiry is ignored in the load cycle and the one after, so stale levels never skip a state.
module traffic_light_ctrl #(
  parameter logic [4:0] T_MAIN_GREEN = 5'd10,
  parameter logic [4:0] T_SIDE_GREEN = 5'd6,
  parameter logic [4:0] T_YELLOW     = 5'd3,
  parameter logic [4:0] T_ALL_RED    = 5'd1,
  parameter logic [4:0] T_WALK       = 5'd8
) (
  input  logic                 clock,
  input  logic                 reset,
  traffic_light_ctrl_if.slave  bus
);

  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] MAIN_GREEN  = 3'd1;
  localparam logic [2:0] MAIN_YELLOW = 3'd2;
  localparam logic [2:0] ALL_RED1    = 3'd3;
  localparam logic [2:0] SIDE_GREEN  = 3'd4;
  localparam logic [2:0] SIDE_YELLOW = 3'd5;
  localparam logic [2:0] WALK        = 3'd6;
  localparam logic [2:0] ALL_RED2    = 3'd7;

  // Lamp encoding {red,yellow,green}
  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       advance;
  logic       start_q;
  logic       start_d;
  logic [4:0] value_q;
  logic [2:0] main_q;
  logic [2:0] side_q;
  logic       walk_q;
  logic       walk_pending;
  logic       expired_ok;

  // Timer load value for the state being entered
  function automatic logic [4:0] duration(input logic [2:0] st);
    case (st)
      MAIN_GREEN:  duration = T_MAIN_GREEN;
      MAIN_YELLOW: duration = T_YELLOW;
      ALL_RED1:    duration = T_ALL_RED;
      SIDE_GREEN:  duration = T_SIDE_GREEN;
      SIDE_YELLOW: duration = T_YELLOW;
      WALK:        duration = T_WALK;
      ALL_RED2:    duration = T_ALL_RED;
      default:     duration = 5'd0;
    endcase
  endfunction

  function automatic logic [2:0] main_lamp(input logic [2:0] st);
    case (st)
      MAIN_GREEN:  main_lamp = LAMP_G;
      MAIN_YELLOW: main_lamp = LAMP_Y;
      default:     main_lamp = LAMP_R;
    endcase
  endfunction

  function automatic logic [2:0] side_lamp(input logic [2:0] st);
    case (st)
      SIDE_GREEN:  side_lamp = LAMP_G;
      SIDE_YELLOW: side_lamp = LAMP_Y;
      default:     side_lamp = LAMP_R;
    endcase
  endfunction

  // The Timer needs the load pulse plus one cycle before its expired level reflects the new count
  assign expired_ok = bus.expired && !start_q && !start_d;

  // Next-state selection; advance marks an edge on which a state (re)entry happens
  always_comb begin
    state_nxt = state;
    advance   = 1'b0;
    case (state)
      IDLE: begin
        advance   = 1'b1;
        state_nxt = MAIN_GREEN;
      end
      MAIN_GREEN: begin
        if (expired_ok) begin
          advance   = 1'b1;
          state_nxt = (bus.sensor || walk_pending) ? MAIN_YELLOW : MAIN_GREEN;
        end
      end
      MAIN_YELLOW: begin
        if (expired_ok) begin
          advance   = 1'b1;
          state_nxt = ALL_RED1;
        end
      end
      ALL_RED1: begin
        if (expired_ok) begin
          advance   = 1'b1;
          state_nxt = walk_pending ? WALK : SIDE_GREEN;
        end
      end
      SIDE_GREEN: begin
        if (expired_ok) begin
          advance   = 1'b1;
          state_nxt = SIDE_YELLOW;
        end
      end
      SIDE_YELLOW: begin
        if (expired_ok) begin
          advance   = 1'b1;
          state_nxt = ALL_RED2;
        end
      end
      WALK: begin
        if (expired_ok) begin
          advance   = 1'b1;
          state_nxt = ALL_RED2;
        end
      end
      ALL_RED2: begin
        if (expired_ok) begin
          advance   = 1'b1;
          state_nxt = MAIN_GREEN;
        end
      end
      default: begin
        advance   = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  // State, timer load and lamp registers all update together on a state entry
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      start_q <= 1'b0;
      start_d <= 1'b0;
      value_q <= 5'd0;
      main_q  <= LAMP_R;
      side_q  <= LAMP_R;
      walk_q  <= 1'b0;
    end else begin
      start_q <= advance;
      start_d <= start_q;
      if (advance) begin
        state   <= state_nxt;
        value_q <= duration(state_nxt);
        main_q  <= main_lamp(state_nxt);
        side_q  <= side_lamp(state_nxt);
        walk_q  <= (state_nxt == WALK);
      end
    end
  end

  // Pedestrian request latch: cleared on WALK entry, requests while in WALK are absorbed
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      walk_pending <= 1'b0;
    end else if (advance && state_nxt == WALK) begin
      walk_pending <= 1'b0;
    end else if (bus.walk_request && state != WALK) begin
      walk_pending <= 1'b1;
    end
  end

  assign bus.start_timer = start_q;
  assign bus.value       = value_q;
  assign bus.main_light  = main_q;
  assign bus.side_light  = side_q;
  assign bus.walk        = walk_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: reset values, full cycle, walk service, expiry masking, async reset.
module tb_traffic_light_ctrl;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  traffic_light_ctrl_if tl_if ();

  traffic_light_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (tl_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packs {start_timer, value, main, side, walk} for one comparison
  function automatic logic [31:0] outs();
    return {19'd0, tl_if.start_timer, tl_if.value, tl_if.main_light, tl_if.side_light, tl_if.walk};
  endfunction

  function automatic logic [31:0] want(input logic st, input logic [4:0] v,
                                       input logic [2:0] m, input logic [2:0] s, input logic w);
    return {19'd0, st, v, m, s, w};
  endfunction

  // Called at the negedge of a load-pulse cycle. Checks pulse and two hold cycles,
  // optionally idles longer, then presents a qualified expiry; returns at the next load-pulse negedge.
  task automatic phase(input string tag, input logic [4:0] v, input logic [2:0] m,
                       input logic [2:0] s, input logic w, input int idle,
                       input logic early, input logic sens, input logic wreq);
    chk({tag, "_pulse"}, outs(), want(1'b1, v, m, s, w));
    tl_if.expired      = early;
    tl_if.walk_request = wreq;
    @(negedge clock);
    tl_if.walk_request = 1'b0;
    chk({tag, "_hold1"}, outs(), want(1'b0, v, m, s, w));
    @(negedge clock);
    chk({tag, "_hold2"}, outs(), want(1'b0, v, m, s, w));
    for (int i = 0; i < idle; i++) begin
      tl_if.expired = 1'b0;
      @(negedge clock);
      chk({tag, "_idle"}, outs(), want(1'b0, v, m, s, w));
    end
    tl_if.expired = 1'b1;
    tl_if.sensor  = sens;
    @(negedge clock);
    tl_if.expired = 1'b0;
    tl_if.sensor  = 1'b0;
  endtask

  initial begin
    reset              = 1'b0;
    tl_if.sensor       = 1'b0;
    tl_if.walk_request = 1'b0;
    tl_if.expired      = 1'b0;

    @(negedge clock);
    chk("reset_outs", outs(), want(1'b0, 5'd0, R, R, 1'b0));
    chk("reset_pending", {31'd0, dut.walk_pending}, 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // Main green re-entry with expired held through the pulse (masking), then sensor service
    phase("mg_reenter", 5'd10, G, R, 1'b0, 1, 1'b1, 1'b0, 1'b0);
    phase("mg_sensor",  5'd10, G, R, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    phase("my",         5'd3,  Y, R, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    phase("ar1",        5'd1,  R, R, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    phase("sg",         5'd6,  R, G, 1'b0, 2, 1'b0, 1'b0, 1'b0);
    phase("sy",         5'd3,  R, Y, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    phase("ar2",        5'd1,  R, R, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // Pedestrian request during main green: walk precedes side service
    phase("mg_wreq",    5'd10, G, R, 1'b0, 0, 1'b0, 1'b1, 1'b1);
    chk("pending_set", {31'd0, dut.walk_pending}, 32'd1);
    phase("my_w",       5'd3,  Y, R, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    phase("ar1_w",      5'd1,  R, R, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    // Request in the WALK entry cycle is absorbed
    phase("walk",       5'd8,  R, R, 1'b1, 1, 1'b1, 1'b0, 1'b1);
    phase("ar2_w",      5'd1,  R, R, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("pending_absorbed", {31'd0, dut.walk_pending}, 32'd0);
    phase("mg_after_w", 5'd10, G, R, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // Side service again, then asynchronous reset mid side green
    phase("mg_s2",      5'd10, G, R, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    phase("my_s2",      5'd3,  Y, R, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    phase("ar1_s2",     5'd1,  R, R, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("sg2_pulse", outs(), want(1'b1, 5'd6, R, G, 1'b0));
    tl_if.walk_request = 1'b1;
    @(negedge clock);
    tl_if.walk_request = 1'b0;
    chk("sg2_pending", {31'd0, dut.walk_pending}, 32'd1);
    tl_if.expired = 1'b1;
    #2 reset = 1'b0;
    #1 chk("async_reset", outs(), want(1'b0, 5'd0, R, R, 1'b0));
    chk("async_reset_pending", {31'd0, dut.walk_pending}, 32'd0);
    @(negedge clock);
    chk("reset_held", outs(), want(1'b0, 5'd0, R, R, 1'b0));
    reset = 1'b1;
    @(negedge clock);
    // Restart ignores the high expired level; pending cleared so sensor=0 re-enters main green
    phase("mg_restart", 5'd10, G, R, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    chk("mg_final_pulse", outs(), want(1'b1, 5'd10, G, R, 1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
